// File: rtl/regfile_wb_scheduler_if.sv
// Issue/writeback handshake bundle for the register-file write-port scheduler.
// The master side is issue logic plus both writeback requesters; the slave side is the scheduler.
interface regfile_wb_scheduler_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              rsv_valid_i;
   logic [ADDR_W-1:0] rsv_addr_i;
   logic              rsv_ready_o;

   logic              req0_valid_i;
   logic [ADDR_W-1:0] req0_addr_i;
   logic [DATA_W-1:0] req0_data_i;
   logic              req0_ready_o;

   logic              req1_valid_i;
   logic [ADDR_W-1:0] req1_addr_i;
   logic [DATA_W-1:0] req1_data_i;
   logic              req1_ready_o;

   logic [ADDR_W-1:0] chk_addr1_i;
   logic [ADDR_W-1:0] chk_addr2_i;
   logic              hazard_o;

   modport master (
      output rsv_valid_i, rsv_addr_i,
      output req0_valid_i, req0_addr_i, req0_data_i,
      output req1_valid_i, req1_addr_i, req1_data_i,
      output chk_addr1_i, chk_addr2_i,
      input  rsv_ready_o, req0_ready_o, req1_ready_o, hazard_o
   );

   modport slave (
      input  rsv_valid_i, rsv_addr_i,
      input  req0_valid_i, req0_addr_i, req0_data_i,
      input  req1_valid_i, req1_addr_i, req1_data_i,
      input  chk_addr1_i, chk_addr2_i,
      output rsv_ready_o, req0_ready_o, req1_ready_o, hazard_o
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the register-file write port, with a per-register pending
// scoreboard that drives the issue-stage hazard signal.
module regfile_wb_scheduler #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int MAX_PENDING = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   regfile_wb_scheduler_if.slave    bus,
   output logic                     RegWrite_o,
   output logic [ADDR_W-1:0]        RDaddr_o,
   output logic [DATA_W-1:0]        RDdata_o,
   output logic [(1<<ADDR_W)-1:0]   pending_o,
   output logic [ADDR_W:0]          pending_cnt_o,
   output logic                     unres_wr_o
);

   localparam int              NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(MAX_PENDING);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

   typedef enum logic {FAVOR_REQ0, FAVOR_REQ1} rr_e;

   rr_e                 rr_q, rr_d;
   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;

   logic                gnt0, gnt1;
   logic                wb_fire, wb_nonzero, wb_reserved;
   logic [ADDR_W-1:0]   wb_addr;
   logic [DATA_W-1:0]   wb_data;
   logic                rsv_ready, rsv_accept;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      rr_d = rr_q;
      if (bus.req0_valid_i && bus.req1_valid_i) begin
         if (rr_q == FAVOR_REQ0) gnt0 = 1'b1;
         else                    gnt1 = 1'b1;
      end else begin
         gnt0 = bus.req0_valid_i;
         gnt1 = bus.req1_valid_i;
      end
      // Favour whoever lost; idle cycles leave the pointer alone.
      if (gnt0)      rr_d = FAVOR_REQ1;
      else if (gnt1) rr_d = FAVOR_REQ0;
   end

   assign wb_fire     = gnt0 | gnt1;
   assign wb_addr     = gnt1 ? bus.req1_addr_i : bus.req0_addr_i;
   assign wb_data     = gnt1 ? bus.req1_data_i : bus.req0_data_i;
   assign wb_nonzero  = wb_fire && (wb_addr != '0);
   assign wb_reserved = pending_q[wb_addr];

   assign rsv_ready  = (bus.rsv_addr_i == '0) ||
                       (!pending_q[bus.rsv_addr_i] && (cnt_q < MAX_CNT));
   assign rsv_accept = bus.rsv_valid_i && rsv_ready && (bus.rsv_addr_i != '0);

   always_comb begin
      pending_d = pending_q;
      cnt_d     = cnt_q;
      if (wb_nonzero && wb_reserved) pending_d[wb_addr] = 1'b0;
      if (rsv_accept)                pending_d[bus.rsv_addr_i] = 1'b1;
      // Unreserved writes clear nothing, so the count cannot underflow.
      case ({rsv_accept, wb_nonzero && wb_reserved})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared by reset like any other state.
         rr_q       <= FAVOR_REQ0;
         pending_q  <= '0;
         cnt_q      <= '0;
         RegWrite_o <= 1'b0;
         RDaddr_o   <= '0;
         RDdata_o   <= '0;
         unres_wr_o <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         pending_q  <= pending_d;
         cnt_q      <= cnt_d;
         RegWrite_o <= wb_nonzero;
         unres_wr_o <= wb_nonzero && !wb_reserved;
         if (wb_nonzero) begin
            RDaddr_o <= wb_addr;
            RDdata_o <= wb_data;
         end
      end
   end

   assign bus.rsv_ready_o  = rsv_ready;
   assign bus.req0_ready_o = gnt0;
   assign bus.req1_ready_o = gnt1;
   assign bus.hazard_o     = pending_q[bus.chk_addr1_i] | pending_q[bus.chk_addr2_i];
   assign pending_o        = pending_q;
   assign pending_cnt_o    = cnt_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reserve/write/clear, fairness, capacity,
// register 0, unreserved writes and mid-operation reset.
module tb_regfile_wb_scheduler;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              reg_write;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [31:0]       pending;
   logic [ADDR_W:0]   pending_cnt;
   logic              unres_wr;

   int checks   = 0;
   int failures = 0;

   regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_PENDING(8)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .bus           (bus),
      .RegWrite_o    (reg_write),
      .RDaddr_o      (rd_addr),
      .RDdata_o      (rd_data),
      .pending_o     (pending),
      .pending_cnt_o (pending_cnt),
      .unres_wr_o    (unres_wr)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      bus.rsv_valid_i  = 1'b0;
      bus.rsv_addr_i   = '0;
      bus.req0_valid_i = 1'b0;
      bus.req0_addr_i  = '0;
      bus.req0_data_i  = '0;
      bus.req1_valid_i = 1'b0;
      bus.req1_addr_i  = '0;
      bus.req1_data_i  = '0;
      bus.chk_addr1_i  = '0;
      bus.chk_addr2_i  = '0;
   endtask

   // Leaves the bench at a falling edge with reset just released: that cycle is cycle 0.
   task automatic do_reset();
      @(negedge clk_i);
      idle();
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%0h exp=0", pending); end
      checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
      checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", reg_write); end
      checks++; if (rd_addr !== 5'd0 || rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd got=%0d/%0h exp=0/0", rd_addr, rd_data); end
      checks++; if (unres_wr !== 1'b0) begin failures++; $display("FAIL reset_unres got=%0b exp=0", unres_wr); end
      checks++; if (bus.hazard_o !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0b exp=0", bus.hazard_o); end
   endtask

   task automatic test_basic();
      do_reset();
      bus.rsv_valid_i = 1'b1;
      bus.rsv_addr_i  = 5'd5;
      #1;
      checks++; if (bus.rsv_ready_o !== 1'b1) begin failures++; $display("FAIL basic_rsv_ready got=%0b exp=1", bus.rsv_ready_o); end
      @(negedge clk_i);
      bus.rsv_valid_i = 1'b0;
      bus.chk_addr1_i = 5'd5;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) begin
            bus.req0_valid_i = 1'b1;
            bus.req0_addr_i  = 5'd5;
            bus.req0_data_i  = 32'hDEADBEEF;
         end
         #1;
         checks++; if (pending[5] !== 1'b1) begin failures++; $display("FAIL basic_pending_c%0d got=%0b exp=1", c, pending[5]); end
         checks++; if (bus.hazard_o !== 1'b1) begin failures++; $display("FAIL basic_hazard_c%0d got=%0b exp=1", c, bus.hazard_o); end
         @(negedge clk_i);
      end
      bus.req0_valid_i = 1'b0;
      #1;
      checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL basic_regwrite got=%0b exp=1", reg_write); end
      checks++; if (rd_addr !== 5'd5) begin failures++; $display("FAIL basic_rdaddr got=%0d exp=5", rd_addr); end
      checks++; if (rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rddata got=%0h exp=deadbeef", rd_data); end
      checks++; if (bus.hazard_o !== 1'b0) begin failures++; $display("FAIL basic_hazard_c4 got=%0b exp=0", bus.hazard_o); end
      checks++; if (pending_cnt !== 6'd0 || unres_wr !== 1'b0) begin failures++; $display("FAIL basic_cnt_unres got=%0d/%0b exp=0/0", pending_cnt, unres_wr); end
      @(negedge clk_i);
      #1;
      checks++; if (reg_write !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL basic_hold got=%0b/%0d/%0h exp=0/5/deadbeef", reg_write, rd_addr, rd_data);
      end
   endtask

   task automatic test_fairness();
      logic exp0;
      do_reset();
      bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd1; bus.req0_data_i = 32'hAAAA0001;
      bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd2; bus.req1_data_i = 32'hBBBB0002;
      for (int i = 0; i < 4; i++) begin
         exp0 = (i % 2 == 0);
         #1;
         checks++; if (bus.req0_ready_o !== exp0 || bus.req1_ready_o !== !exp0) begin
            failures++; $display("FAIL fair_grant_%0d got=%0b%0b exp=%0b%0b", i, bus.req0_ready_o, bus.req1_ready_o, exp0, !exp0);
         end
         if (i > 0) begin
            checks++; if (reg_write !== 1'b1 || rd_addr !== (exp0 ? 5'd2 : 5'd1)) begin
               failures++; $display("FAIL fair_write_%0d got=%0b/%0d exp=1/%0d", i, reg_write, rd_addr, exp0 ? 2 : 1);
            end
         end
         @(negedge clk_i);
      end
      idle();
      #1;
      checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd2 || rd_data !== 32'hBBBB0002) begin
         failures++; $display("FAIL fair_last_write got=%0b/%0d/%0h exp=1/2/bbbb0002", reg_write, rd_addr, rd_data);
      end
   endtask

   task automatic test_capacity();
      do_reset();
      for (int r = 1; r <= 8; r++) begin
         bus.rsv_valid_i = 1'b1;
         bus.rsv_addr_i  = 5'(r);
         #1;
         checks++; if (bus.rsv_ready_o !== 1'b1) begin failures++; $display("FAIL cap_rsv_x%0d got=%0b exp=1", r, bus.rsv_ready_o); end
         @(negedge clk_i);
      end
      bus.rsv_addr_i = 5'd9;
      #1;
      checks++; if (bus.rsv_ready_o !== 1'b0 || pending_cnt !== 6'd8) begin
         failures++; $display("FAIL cap_full got=%0b/%0d exp=0/8", bus.rsv_ready_o, pending_cnt);
      end
      @(negedge clk_i);
      bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd1; bus.req0_data_i = 32'h11;
      #1;
      checks++; if (bus.rsv_ready_o !== 1'b0 || bus.req0_ready_o !== 1'b1) begin
         failures++; $display("FAIL cap_same_cycle got=%0b/%0b exp=0/1", bus.rsv_ready_o, bus.req0_ready_o);
      end
      @(negedge clk_i);
      bus.req0_valid_i = 1'b0;
      #1;
      checks++; if (bus.rsv_ready_o !== 1'b1 || pending_cnt !== 6'd7) begin
         failures++; $display("FAIL cap_accept got=%0b/%0d exp=1/7", bus.rsv_ready_o, pending_cnt);
      end
      @(negedge clk_i);
      idle();
      #1;
      checks++; if (pending_cnt !== 6'd8 || pending !== 32'h0000_03FC) begin
         failures++; $display("FAIL cap_final got=%0d/%0h exp=8/3fc", pending_cnt, pending);
      end
   endtask

   task automatic test_dup_x0();
      do_reset();
      bus.rsv_valid_i = 1'b1;
      bus.rsv_addr_i  = 5'd7;
      #1;
      checks++; if (bus.rsv_ready_o !== 1'b1) begin failures++; $display("FAIL dup_first got=%0b exp=1", bus.rsv_ready_o); end
      @(negedge clk_i);
      #1;
      checks++; if (bus.rsv_ready_o !== 1'b0 || pending_cnt !== 6'd1) begin
         failures++; $display("FAIL dup_second got=%0b/%0d exp=0/1", bus.rsv_ready_o, pending_cnt);
      end
      @(negedge clk_i);
      bus.rsv_addr_i   = 5'd0;
      bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd0; bus.req0_data_i = 32'h1234;
      bus.chk_addr1_i  = 5'd0;
      #1;
      checks++; if (bus.req0_ready_o !== 1'b1 || bus.rsv_ready_o !== 1'b1) begin
         failures++; $display("FAIL x0_ready got=%0b/%0b exp=1/1", bus.req0_ready_o, bus.rsv_ready_o);
      end
      checks++; if (bus.hazard_o !== 1'b0) begin failures++; $display("FAIL x0_hazard got=%0b exp=0", bus.hazard_o); end
      @(negedge clk_i);
      idle();
      bus.chk_addr2_i = 5'd7;
      #1;
      checks++; if (reg_write !== 1'b0 || unres_wr !== 1'b0) begin
         failures++; $display("FAIL x0_write got=%0b/%0b exp=0/0", reg_write, unres_wr);
      end
      checks++; if (pending !== 32'h0000_0080 || pending_cnt !== 6'd1) begin
         failures++; $display("FAIL x0_pending got=%0h/%0d exp=80/1", pending, pending_cnt);
      end
      checks++; if (bus.hazard_o !== 1'b1) begin failures++; $display("FAIL x7_hazard got=%0b exp=1", bus.hazard_o); end
   endtask

   task automatic test_unreserved();
      do_reset();
      bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd12; bus.req1_data_i = 32'h55AA;
      #1;
      checks++; if (bus.req1_ready_o !== 1'b1) begin failures++; $display("FAIL unres_ready got=%0b exp=1", bus.req1_ready_o); end
      @(negedge clk_i);
      idle();
      #1;
      checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd12 || rd_data !== 32'h55AA) begin
         failures++; $display("FAIL unres_write got=%0b/%0d/%0h exp=1/12/55aa", reg_write, rd_addr, rd_data);
      end
      checks++; if (unres_wr !== 1'b1 || pending_cnt !== 6'd0) begin
         failures++; $display("FAIL unres_pulse got=%0b/%0d exp=1/0", unres_wr, pending_cnt);
      end
      @(negedge clk_i);
      #1;
      checks++; if (unres_wr !== 1'b0 || reg_write !== 1'b0) begin
         failures++; $display("FAIL unres_single got=%0b/%0b exp=0/0", unres_wr, reg_write);
      end
   endtask

   task automatic test_reset_mid();
      logic [ADDR_W-1:0] regs [3];
      regs = '{5'd3, 5'd4, 5'd6};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.rsv_valid_i = 1'b1;
         bus.rsv_addr_i  = regs[i];
         #1;
         checks++; if (bus.rsv_ready_o !== 1'b1) begin failures++; $display("FAIL mid_rsv_%0d got=%0b exp=1", i, bus.rsv_ready_o); end
         @(negedge clk_i);
      end
      bus.rsv_valid_i  = 1'b0;
      bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd3; bus.req0_data_i = 32'hC0FFEE;
      #1;
      checks++; if (pending !== 32'h58 || pending_cnt !== 6'd3 || bus.req0_ready_o !== 1'b1) begin
         failures++; $display("FAIL mid_before got=%0h/%0d/%0b exp=58/3/1", pending, pending_cnt, bus.req0_ready_o);
      end
      @(negedge clk_i);
      idle();
      rst_i = 1'b1;
      #1;
      checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd3) begin
         failures++; $display("FAIL mid_inflight got=%0b/%0d exp=1/3", reg_write, rd_addr);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd10; bus.req0_data_i = 32'h10;
      bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd11; bus.req1_data_i = 32'h11;
      #1;
      checks++; if (pending !== 32'h0 || pending_cnt !== 6'd0 || reg_write !== 1'b0) begin
         failures++; $display("FAIL mid_after got=%0h/%0d/%0b exp=0/0/0", pending, pending_cnt, reg_write);
      end
      checks++; if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin
         failures++; $display("FAIL mid_first_tie got=%0b%0b exp=10", bus.req0_ready_o, bus.req1_ready_o);
      end
      @(negedge clk_i);
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_basic();
      test_fairness();
      test_capacity();
      test_dup_x0();
      test_unreserved();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 register file, which has one write port, two read ports and write-to-read bypass.
- Two writeback requesters share that port: req0 is the ALU/load path, req1 is the long-latency unit.
- A per-register pending scoreboard is set when an instruction reserves a destination and cleared when its writeback is granted.
- Issue logic reads `hazard_o` to stall consumers of in-flight results.

Parameters:
- `DATA_W`, 32, width of write data.
- `ADDR_W`, 5, register address width (32 registers).
- `MAX_PENDING`, 8, maximum simultaneously reserved destinations (1..31).

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `rsv_valid_i`  in  1  issue wants to reserve a destination.
- `rsv_addr_i`  in  ADDR_W  destination register to reserve.
- `rsv_ready_o`  out  1  reservation accepted this cycle when high with `rsv_valid_i`.
- `req0_valid_i`  in  1  requester 0 has a writeback.
- `req0_addr_i`  in  ADDR_W  requester 0 destination.
- `req0_data_i`  in  DATA_W  requester 0 data.
- `req0_ready_o`  out  1  requester 0 granted this cycle.
- `req1_valid_i`, `req1_addr_i`, `req1_data_i`, `req1_ready_o`: same as req0, for requester 1.
- `chk_addr1_i`  in  ADDR_W  source register 1 of the issuing instruction.
- `chk_addr2_i`  in  ADDR_W  source register 2 of the issuing instruction.
- `hazard_o`  out  1  either source is pending.
- `RegWrite_o`  out  1  register-file write enable.
- `RDaddr_o`  out  ADDR_W  register-file write address.
- `RDdata_o`  out  DATA_W  register-file write data.
- `pending_o`  out  32  scoreboard vector; bit 0 is always 0.
- `pending_cnt_o`  out  ADDR_W+1  number of set pending bits.
- `unres_wr_o`  out  1  one-cycle pulse: a granted write targeted a non-pending, nonzero register.

Behaviour:
- **Reset** (`rst_i` high at an edge, including mid-operation):
  - `pending_o`=0, `pending_cnt_o`=0, `RegWrite_o`=0, `RDaddr_o`=0, `RDdata_o`=0, `unres_wr_o`=0.
  - Round-robin pointer is set to favour req0.
  - In-flight requests are dropped; requesters re-present them after reset.
- **Arbitration** (combinational grant, at most one per cycle):
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not granted last; after reset, req0 wins the first tie.
  - Pointer updates only on a tie-free or tie grant, never on idle cycles.
  - `reqN_ready_o` = grant to N; the handshake completes on valid && ready at the edge.
  - A requester holds its valid, addr and data stable until ready.
- **Write stage** (registered, latency 1):
  - A grant in cycle N drives `RegWrite_o`=1 with the granted addr/data in cycle N+1.
  - The register file commits at the end of N+1 and bypasses to readers during N+1.
  - No grant in N gives `RegWrite_o`=0 in N+1; `RDaddr_o`/`RDdata_o` hold their previous values.
- **Register 0:**
  - A granted write to addr 0 is consumed (ready=1) but gives `RegWrite_o`=0 in N+1.
  - A reservation of addr 0 is always ready and sets nothing.
- **Scoreboard:**
  - The pending bit for the granted addr clears at the edge ending cycle N, so a consumer checking in N+1 sees no hazard and reads the bypassed value.
  - `rsv_ready_o` = (addr==0) || (!pending[addr] && `pending_cnt_o` < `MAX_PENDING`).
  - `rsv_ready_o` uses the current, pre-edge state; no write-after-write reservation is allowed.
  - Accepted reservation: sets pending[addr] at the edge.
  - Reservation and grant in the same cycle: both apply.
    - Different addrs: the count is unchanged (+1 and -1).
    - Same addr: the reservation was refused, since the bit was set.
- **Hazard:**
  - `hazard_o` = pending[`chk_addr1_i`] | pending[`chk_addr2_i`], combinational from the current scoreboard.
  - Addr 0 never raises a hazard.
- **Unreserved write:**
  - A granted nonzero addr whose pending bit is 0 is still written.
  - `unres_wr_o` pulses in N+1.
  - The count does not underflow.

Test Plan:
- **Basic reserve/write/clear:**
  - Stimulus: after reset, reserve x5 in cycle 0; req0 writes x5=0xDEADBEEF in cycle 3.
  - Required: `pending_o`[5]=1 in cycles 1-3; `hazard_o`=1 with `chk_addr1_i`=5 in cycles 1-3; in cycle 4, `RegWrite_o`=1, `RDaddr_o`=5, `RDdata_o`=0xDEADBEEF, `hazard_o`=0.
- **Arbitration fairness:**
  - Stimulus: req0 (x1) and req1 (x2) valid together for 4 cycles, each re-presenting after grant.
  - Required: grants req0, req1, req0, req1; one `RegWrite_o` per cycle.
- **Capacity:**
  - Stimulus: reserve x1..x8, then attempt x9; write x1 and reserve x9 in the same cycle.
  - Required: x9 is refused (`rsv_ready_o`=0, count=8), then accepted in the next cycle with count=8.
- **Duplicate / register 0:**
  - Stimulus: reserve x7 twice; write to x0 with data 0x1234.
  - Required: the second reserve of x7 gets `rsv_ready_o`=0; the x0 write gets `req0_ready_o`=1 and `RegWrite_o`=0; pending unchanged.
- **Unreserved write:**
  - Stimulus: req1 writes x12 with no reservation.
  - Required: `RegWrite_o`=1, `RDaddr_o`=12, `unres_wr_o`=1 for one cycle; count stays 0.
- **Reset mid-operation:**
  - Stimulus: three pending registers and a grant in flight; assert `rst_i` for 1 cycle.
  - Required: next cycle `pending_o`=0, count=0, `RegWrite_o`=0; the first tie after reset goes to req0.
